write_back_arbiter: RTL and testbench

// - Shares the single register-file write port between the ALU result path (req A) and the load-data return path (req L).
// - Sits in front of write_back; its registered outputs drive rd_write_index/rd_write_data/rd_write_enable.
// - Fixed priority to loads, plus an aging counter that forces an ALU grant after STARVE_LIMIT stalled cycles.
// - Counts retired (accepted) requests in a 64-bit instret counter.

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_age_counter.sv | 41 ++++
 rtl/write_back_arbiter.sv | 106 ++++++++++
 tb/tb_write_back_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package wb_arb_pkg;

   typedef enum logic {
      PRI_LOAD = 1'b0,
      PRI_ALU  = 1'b1
   } wb_pri_e;

   localparam int INSTRET_W = 64;
   // Wide enough for the largest legal starvation limit (15).
   localparam int AGE_CNT_W = 4;

endpackage

// File: rtl/wb_age_counter.sv
// Saturating age counter. Clear has priority over increment.
// hit flags that the value being loaded on this edge equals LIMIT.
module wb_age_counter
   import wb_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [AGE_CNT_W-1:0] LIMIT_V = AGE_CNT_W'(LIMIT);

   logic [AGE_CNT_W-1:0] count_q;
   logic [AGE_CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != LIMIT_V)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Looking at the next value lets the priority flip on the same edge the
   // count reaches LIMIT, so the requester stalls exactly LIMIT cycles.
   assign hit = (count_d == LIMIT_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/write_back_arbiter.sv
// Arbitrates the single register-file write port between ALU results and
// load returns: loads win by default, an aging counter forces an ALU grant.
module write_back_arbiter
   import wb_arb_pkg::*;
#(
   parameter int X_LENGTH     = 32,
   parameter int REG_IDX_W    = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_IDX_W-1:0]  alu_rd_index,
   input  logic [X_LENGTH-1:0]   alu_result,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_IDX_W-1:0]  ld_rd_index,
   input  logic [X_LENGTH-1:0]   ld_data,
   output logic [REG_IDX_W-1:0]  rd_write_index,
   output logic [X_LENGTH-1:0]   rd_write_data,
   output logic                  rd_write_enable,
   output logic [INSTRET_W-1:0]  instret
);

   wb_pri_e               state_q, state_d;
   logic                  alu_xfer, ld_xfer, age_hit;
   logic [REG_IDX_W-1:0]  wr_index_q, wr_index_d;
   logic [X_LENGTH-1:0]   wr_data_q, wr_data_d;
   logic                  wr_en_q, wr_en_d;
   logic [INSTRET_W-1:0]  instret_q, instret_d;

   // Grant logic: depends only on valids and priority, never on payload.
   always_comb begin
      alu_ready = 1'b0;
      ld_ready  = 1'b0;
      case (state_q)
         PRI_ALU: begin
            alu_ready = alu_valid;
            ld_ready  = ld_valid && !alu_valid;
         end
         default: begin
            ld_ready  = ld_valid;
            alu_ready = alu_valid && !ld_valid;
         end
      endcase
   end

   assign alu_xfer = alu_valid && alu_ready;
   assign ld_xfer  = ld_valid && ld_ready;

   wb_age_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (alu_valid && !alu_ready),
      .clr   (!alu_valid || alu_xfer),
      .hit   (age_hit)
   );

   // An ALU transfer clears the counter, so hit is never set alongside it.
   always_comb begin
      state_d = age_hit ? PRI_ALU : PRI_LOAD;
   end

   always_comb begin
      wr_index_d = wr_index_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = 1'b0;
      instret_d  = instret_q;
      if (ld_xfer) begin
         wr_index_d = ld_rd_index;
         wr_data_d  = ld_data;
         wr_en_d    = (ld_rd_index != '0);
         instret_d  = instret_q + 1'b1;
      end else if (alu_xfer) begin
         wr_index_d = alu_rd_index;
         wr_data_d  = alu_result;
         wr_en_d    = (alu_rd_index != '0);
         instret_d  = instret_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PRI_LOAD;
         wr_index_q <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_index_q <= wr_index_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         instret_q  <= instret_d;
      end
   end

   assign rd_write_index  = wr_index_q;
   assign rd_write_data   = wr_data_q;
   assign rd_write_enable = wr_en_q;
   assign instret         = instret_q;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed self-checking bench for write_back_arbiter (STARVE_LIMIT = 4).
module tb_write_back_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, ld_valid;
   logic        alu_ready, ld_ready;
   logic [4:0]  alu_rd_index, ld_rd_index;
   logic [31:0] alu_result, ld_data;
   logic [4:0]  rd_write_index;
   logic [31:0] rd_write_data;
   logic        rd_write_enable;
   logic [63:0] instret;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [63:0] exp_instret;
   logic [37:0] exp_wr;

   always #5 clk = ~clk;

   write_back_arbiter #(
      .X_LENGTH     (32),
      .REG_IDX_W    (5),
      .STARVE_LIMIT (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_valid       (alu_valid),
      .alu_ready       (alu_ready),
      .alu_rd_index    (alu_rd_index),
      .alu_result      (alu_result),
      .ld_valid        (ld_valid),
      .ld_ready        (ld_ready),
      .ld_rd_index     (ld_rd_index),
      .ld_data         (ld_data),
      .rd_write_index  (rd_write_index),
      .rd_write_data   (rd_write_data),
      .rd_write_enable (rd_write_enable),
      .instret         (instret)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd_index = '0; alu_result = '0;
      ld_valid  = 1'b0; ld_rd_index  = '0; ld_data    = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== 102'd0) begin
         tests_failed++;
         $display("FAIL reset_init: got en=%0b idx=%0d data=%h instret=%0d, want all 0",
                  rd_write_enable, rd_write_index, rd_write_data, instret);
      end
      rst_n = 1'b1;
      // Start a write so reset lands while the strobe is high.
      alu_valid = 1'b1; alu_rd_index = 5'd7; alu_result = 32'h0000_00A7;
      @(negedge clk);
      alu_valid = 1'b0;
      tests_run++;
      if (rd_write_enable !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_prewrite_en: got %0b, want 1", rd_write_enable);
      end
      #2 rst_n = 1'b0;
      alu_valid = 1'b1; alu_rd_index = 5'd8; alu_result = 32'h0000_00A8;
      #1;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== 102'd0) begin
         tests_failed++;
         $display("FAIL reset_async: got en=%0b idx=%0d data=%h instret=%0d, want all 0",
                  rd_write_enable, rd_write_index, rd_write_data, instret);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({rd_write_enable, instret} !== 65'd0) begin
         tests_failed++;
         $display("FAIL reset_release: got en=%0b instret=%0d, want en=0 instret=0",
                  rd_write_enable, instret);
      end
      exp_instret = 64'd0;
      $display("[TB] reset: async clear and quiet release checked");
   endtask

   task automatic test_solo_alu();
      @(negedge clk);
      alu_valid = 1'b1; alu_rd_index = 5'd5; alu_result = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if ({alu_ready, ld_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL solo_ready: got alu_ready=%0b ld_ready=%0b, want 1 0", alu_ready, ld_ready);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      exp_instret = exp_instret + 64'd1;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 64'd1}) begin
         tests_failed++;
         $display("FAIL solo_write: got en=%0b idx=%0d data=%h instret=%0d, want 1 5 deadbeef 1",
                  rd_write_enable, rd_write_index, rd_write_data, instret);
      end
      $display("[TB] solo alu: x%0d <= %h", rd_write_index, rd_write_data);
      @(negedge clk);
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
         tests_failed++;
         $display("FAIL idle_hold: got en=%0b idx=%0d data=%h, want 0 5 deadbeef",
                  rd_write_enable, rd_write_index, rd_write_data);
      end
   endtask

   task automatic test_contention();
      @(negedge clk);
      ld_valid  = 1'b1; ld_rd_index  = 5'd3; ld_data    = 32'h11;
      alu_valid = 1'b1; alu_rd_index = 5'd4; alu_result = 32'h22;
      #1;
      tests_run++;
      if ({ld_ready, alu_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL contend_grant1: got ld_ready=%0b alu_ready=%0b, want 1 0", ld_ready, alu_ready);
      end
      @(negedge clk);
      ld_valid = 1'b0;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data} !== {1'b1, 5'd3, 32'h11}) begin
         tests_failed++;
         $display("FAIL contend_ld_write: got en=%0b idx=%0d data=%h, want 1 3 11",
                  rd_write_enable, rd_write_index, rd_write_data);
      end
      $display("[TB] contention: load x%0d <= %h", rd_write_index, rd_write_data);
      #1;
      tests_run++;
      if (alu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL contend_grant2: got alu_ready=%0b, want 1", alu_ready);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      exp_instret = exp_instret + 64'd2;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== {1'b1, 5'd4, 32'h22, exp_instret}) begin
         tests_failed++;
         $display("FAIL contend_alu_write: got en=%0b idx=%0d data=%h instret=%0d, want 1 4 22 %0d",
                  rd_write_enable, rd_write_index, rd_write_data, instret, exp_instret);
      end
      $display("[TB] contention: alu x%0d <= %h", rd_write_index, rd_write_data);
   endtask

   task automatic test_starvation();
      logic exp_alu;
      alu_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c > 0) begin
            tests_run++;
            if ({rd_write_enable, rd_write_index, rd_write_data} !== exp_wr) begin
               tests_failed++;
               $display("FAIL starve_write%0d: got en=%0b idx=%0d data=%h, want %h",
                        c - 1, rd_write_enable, rd_write_index, rd_write_data, exp_wr);
            end
            $display("[TB] starve cycle %0d: x%0d <= %h", c - 1, rd_write_index, rd_write_data);
         end
         ld_valid = 1'b1; ld_rd_index = 5'(10 + c); ld_data = 32'h100 + 32'(c);
         if (c == 0) begin
            alu_valid = 1'b1; alu_rd_index = 5'd9; alu_result = 32'h99;
         end else if (c == 5) begin
            alu_rd_index = 5'd12; alu_result = 32'hC;
         end
         exp_alu = (c == 4);
         #1;
         tests_run++;
         if ({alu_ready, ld_ready} !== {exp_alu, !exp_alu}) begin
            tests_failed++;
            $display("FAIL starve_grant%0d: got alu_ready=%0b ld_ready=%0b, want %0b %0b",
                     c, alu_ready, ld_ready, exp_alu, !exp_alu);
         end
         exp_wr = exp_alu ? {1'b1, 5'd9, 32'h99} : {1'b1, 5'(10 + c), 32'h100 + 32'(c)};
         exp_instret = exp_instret + 64'd1;
      end
      @(negedge clk);
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== {exp_wr, exp_instret}) begin
         tests_failed++;
         $display("FAIL starve_last: got en=%0b idx=%0d data=%h instret=%0d, want %h %0d",
                  rd_write_enable, rd_write_index, rd_write_data, instret, exp_wr, exp_instret);
      end
      $display("[TB] starve cycle 5: x%0d <= %h", rd_write_index, rd_write_data);
   endtask

   task automatic test_x0();
      @(negedge clk);
      alu_valid = 1'b1; alu_rd_index = 5'd0; alu_result = 32'h55;
      #1;
      tests_run++;
      if (alu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL x0_ready: got alu_ready=%0b, want 1", alu_ready);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      exp_instret = exp_instret + 64'd1;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== {1'b0, 5'd0, 32'h55, exp_instret}) begin
         tests_failed++;
         $display("FAIL x0_write: got en=%0b idx=%0d data=%h instret=%0d, want 0 0 55 %0d",
                  rd_write_enable, rd_write_index, rd_write_data, instret, exp_instret);
      end
      $display("[TB] x0: accepted, strobe suppressed, instret=%0d", instret);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      exp_instret = 64'd0;
      tests_run++;
      if (instret !== 64'd0) begin
         tests_failed++;
         $display("FAIL b2b_start: got instret=%0d, want 0", instret);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c > 0) begin
            tests_run++;
            if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== {exp_wr, exp_instret}) begin
               tests_failed++;
               $display("FAIL b2b_write%0d: got en=%0b idx=%0d data=%h instret=%0d, want %h %0d",
                        c - 1, rd_write_enable, rd_write_index, rd_write_data, instret, exp_wr, exp_instret);
            end
            $display("[TB] b2b load %0d: x%0d <= %h", c - 1, rd_write_index, rd_write_data);
         end
         ld_valid = 1'b1; ld_rd_index = 5'(c + 1); ld_data = 32'hA0 + 32'(c);
         exp_wr = {1'b1, 5'(c + 1), 32'hA0 + 32'(c)};
         exp_instret = exp_instret + 64'd1;
      end
      @(negedge clk);
      ld_valid = 1'b0;
      tests_run++;
      if ({rd_write_enable, rd_write_index, rd_write_data, instret} !== {exp_wr, 64'd3}) begin
         tests_failed++;
         $display("FAIL b2b_write2: got en=%0b idx=%0d data=%h instret=%0d, want %h 3",
                  rd_write_enable, rd_write_index, rd_write_data, instret, exp_wr);
      end
      $display("[TB] b2b load 2: x%0d <= %h", rd_write_index, rd_write_data);
      @(negedge clk);
      tests_run++;
      if ({rd_write_enable, instret} !== {1'b0, 64'd3}) begin
         tests_failed++;
         $display("FAIL b2b_idle: got en=%0b instret=%0d, want 0 3", rd_write_enable, instret);
      end
   endtask

   initial begin
      exp_instret = 64'd0;
      exp_wr      = '0;
      test_reset();
      test_solo_alu();
      test_contention();
      test_starvation();
      test_x0();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
